// File: rtl/lc3b_pipe_stage_pkg.sv
// Shared LC-3b pipeline types: stage-register state encoding and packed per-stage payloads.
// A stage register carrying one of these payloads uses DATA_WIDTH = $bits(<payload struct>).
package lc3b_pipe_stage_pkg;

  // Encoding is {skid_v, main_v}; 2'b10 is unreachable.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } lc3b_pipe_state;

  typedef logic [15:0] lc3b_word;
  typedef logic [2:0]  lc3b_reg;

  typedef struct packed {
    logic [3:0] opcode;
    logic [3:0] aluop;
    logic       load_regfile;
    logic       load_cc;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] pcmux_sel;
    logic [1:0] regfilemux_sel;
  } lc3b_control_word_t;

  typedef struct packed {
    lc3b_word pc;
    lc3b_word ir;
  } lc3b_if_id_t;

  typedef struct packed {
    lc3b_control_word_t control;
    lc3b_word           pc;
    lc3b_word           sr1;
    lc3b_word           sr2;
    lc3b_word           imm;
    lc3b_reg            dest;
  } lc3b_id_ex_t;

  typedef struct packed {
    lc3b_control_word_t control;
    lc3b_word           pc;
    lc3b_word           alu_out;
    lc3b_word           branch_address;
    lc3b_word           sr2;
    lc3b_reg            dest;
  } lc3b_ex_mem_t;

  typedef struct packed {
    lc3b_control_word_t control;
    lc3b_word           pc;
    lc3b_word           alu_out;
    lc3b_word           mem_out;
    lc3b_word           branch_address;
    lc3b_word           sr2;
    lc3b_reg            dest;
  } lc3b_mem_wb_t;

  localparam int LC3B_IF_ID_WIDTH  = $bits(lc3b_if_id_t);
  localparam int LC3B_ID_EX_WIDTH  = $bits(lc3b_id_ex_t);
  localparam int LC3B_EX_MEM_WIDTH = $bits(lc3b_ex_mem_t);
  localparam int LC3B_MEM_WB_WIDTH = $bits(lc3b_mem_wb_t);

endpackage

// File: rtl/lc3b_sat_counter.sv
// Saturating up-counter with synchronous active-high reset; sticks at all-ones.
module lc3b_sat_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_ONE;
    end
  end

endmodule

// File: rtl/lc3b_pipe_stage.sv
// Elastic LC-3b pipeline-stage register: two-entry skid buffer with registered in_ready and flush.
// Optional stall/bubble performance counters are built when LC3B_PIPE_PERF_EN is defined.
module lc3b_pipe_stage
  import lc3b_pipe_stage_pkg::*;
#(
  parameter int DATA_WIDTH     = 64,
  parameter bit CLEAR_ON_FLUSH = 1'b1,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data
`ifdef LC3B_PIPE_PERF_EN
  ,
  output logic [CNT_WIDTH-1:0]  stall_cnt,
  output logic [CNT_WIDTH-1:0]  bubble_cnt
`endif
);

  logic                  main_v, skid_v, main_v_nxt, skid_v_nxt;
  logic [DATA_WIDTH-1:0] main_d, skid_d, main_d_nxt, skid_d_nxt;
  logic                  accept, drain;
  lc3b_pipe_state        state;

  assign state     = lc3b_pipe_state'({skid_v, main_v});
  assign in_ready  = ~skid_v;
  assign out_valid = main_v;
  assign out_data  = main_d;
  assign accept    = in_valid & in_ready;
  assign drain     = main_v & out_ready;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    main_v_nxt = main_v;
    skid_v_nxt = skid_v;
    main_d_nxt = main_d;
    skid_d_nxt = skid_d;
    if (flush) begin
      main_v_nxt = 1'b0;
      skid_v_nxt = 1'b0;
      if (CLEAR_ON_FLUSH) begin
        main_d_nxt = '0;
        skid_d_nxt = '0;
      end
    end else begin
      case (state)
        ONE: begin
          if (accept && drain) begin
            main_d_nxt = in_data;
          end else if (accept) begin
            skid_v_nxt = 1'b1;
            skid_d_nxt = in_data;
          end else if (drain) begin
            main_v_nxt = 1'b0;
          end
        end
        FULL: begin
          if (drain) begin
            skid_v_nxt = 1'b0;
            main_d_nxt = skid_d;
          end
        end
        default: begin
          // EMPTY; the unreachable 2'b10 also lands here and recovers as EMPTY.
          skid_v_nxt = 1'b0;
          main_v_nxt = accept;
          if (accept) main_d_nxt = in_data;
        end
      endcase
    end
  end

  // NOTE: the payload registers are reset too, so out_data reads zero straight after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_d <= '0;
      skid_d <= '0;
    end else begin
      main_v <= main_v_nxt;
      skid_v <= skid_v_nxt;
      main_d <= main_d_nxt;
      skid_d <= skid_d_nxt;
    end
  end

`ifdef LC3B_PIPE_PERF_EN
  lc3b_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (main_v & ~out_ready),
    .count (stall_cnt)
  );

  lc3b_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_bubble_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (~main_v),
    .count (bubble_cnt)
  );
`else
  logic unused_cnt_width;
  assign unused_cnt_width = ^CNT_WIDTH;
`endif

endmodule

// File: tb/tb_lc3b_pipe_stage.sv
// Directed bench for lc3b_pipe_stage: vector table plus streaming and perf-counter sequences.
module tb_lc3b_pipe_stage;

  localparam int DW  = 64;
  localparam int CW  = 4;
  localparam bit CLR = 1'b1;

  logic          clk;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
`ifdef LC3B_PIPE_PERF_EN
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] bubble_cnt;
`endif

  int errors = 0;
  int checks = 0;

  lc3b_pipe_stage #(
    .DATA_WIDTH     (DW),
    .CLEAR_ON_FLUSH (CLR),
    .CNT_WIDTH      (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data)
`ifdef LC3B_PIPE_PERF_EN
    ,
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic          fl;
    logic          iv;
    logic [DW-1:0] d;
    logic          ordy;
    logic          ev;
    logic [DW-1:0] ed;
    logic          er;
  } vec_t;

  localparam int NVEC = 19;
  vec_t vecs [NVEC];

  // Data expected to survive a flush depends on CLEAR_ON_FLUSH.
  localparam logic [DW-1:0] FL_FULL_D = CLR ? 64'h0 : 64'h5555;
  localparam logic [DW-1:0] FL_ONE_D  = CLR ? 64'h0 : 64'h7777;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive inputs on the falling edge, clock once, sample 1 time unit after the rising edge.
  task automatic step(input logic rst, input logic fl, input logic iv,
                      input logic [DW-1:0] d, input logic ordy);
    @(negedge clk);
    reset     = rst;
    flush     = fl;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    //             rst   fl    iv    d          ordy  ev    ed          er
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 64'hAAAA, 1'b0, 1'b0, 64'h0,      1'b1};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 64'hAAAA, 1'b0, 1'b0, 64'h0,      1'b1};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 64'h0,    1'b0, 1'b0, 64'h0,      1'b1};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 64'h1111, 1'b0, 1'b1, 64'h1111,   1'b1};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 64'h2222, 1'b0, 1'b1, 64'h1111,   1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 64'h3333, 1'b0, 1'b1, 64'h1111,   1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 64'h3333, 1'b1, 1'b1, 64'h2222,   1'b1};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 64'h3333, 1'b1, 1'b1, 64'h3333,   1'b1};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 64'h0,    1'b1, 1'b0, 64'h3333,   1'b1};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 64'h5555, 1'b0, 1'b1, 64'h5555,   1'b1};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 64'h6666, 1'b0, 1'b1, 64'h5555,   1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 64'h4444, 1'b0, 1'b0, FL_FULL_D,  1'b1};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 64'h0,    1'b1, 1'b0, FL_FULL_D,  1'b1};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 64'h7777, 1'b0, 1'b1, 64'h7777,   1'b1};
    vecs[14] = '{1'b0, 1'b1, 1'b1, 64'h8888, 1'b1, 1'b0, FL_ONE_D,   1'b1};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 64'h0,    1'b1, 1'b0, FL_ONE_D,   1'b1};
    vecs[16] = '{1'b0, 1'b0, 1'b1, 64'h9999, 1'b0, 1'b1, 64'h9999,   1'b1};
    vecs[17] = '{1'b1, 1'b1, 1'b1, 64'hBBBB, 1'b1, 1'b0, 64'h0,      1'b1};
    vecs[18] = '{1'b0, 1'b0, 1'b0, 64'h0,    1'b0, 1'b0, 64'h0,      1'b1};

    for (int i = 0; i < NVEC; i++) begin
      step(vecs[i].rst, vecs[i].fl, vecs[i].iv, vecs[i].d, vecs[i].ordy);
      check($sformatf("vec%0d out_valid", i), DW'(out_valid), DW'(vecs[i].ev));
      check($sformatf("vec%0d out_data", i),  out_data,       vecs[i].ed);
      check($sformatf("vec%0d in_ready", i),  DW'(in_ready),  DW'(vecs[i].er));
    end

    // Back-to-back streaming: each payload appears the cycle after its accept edge.
    for (int i = 1; i <= 16; i++) begin
      step(1'b0, 1'b0, 1'b1, DW'(i), 1'b1);
      check($sformatf("stream%0d out_valid", i), DW'(out_valid), DW'(1'b1));
      check($sformatf("stream%0d out_data", i),  out_data,       DW'(i));
      check($sformatf("stream%0d in_ready", i),  DW'(in_ready),  DW'(1'b1));
    end
    step(1'b0, 1'b0, 1'b0, '0, 1'b1);
    check("stream drained out_valid", DW'(out_valid), DW'(1'b0));

`ifdef LC3B_PIPE_PERF_EN
    // Load into ONE, then reset+flush together: counters clear like a plain reset.
    step(1'b0, 1'b0, 1'b1, 64'hCCCC, 1'b0);
    step(1'b1, 1'b1, 1'b1, 64'hDDDD, 1'b0);
    check("rstflush out_valid",   DW'(out_valid),  DW'(1'b0));
    check("rstflush out_data",    out_data,        DW'(0));
    check("rstflush stall_cnt",   DW'(stall_cnt),  DW'(0));
    check("rstflush bubble_cnt",  DW'(bubble_cnt), DW'(0));
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, '0, 1'b0);
    check("perf bubble_cnt 3",    DW'(bubble_cnt), DW'(3));
    check("perf stall_cnt 0",     DW'(stall_cnt),  DW'(0));
    step(1'b0, 1'b0, 1'b1, 64'h1, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0, '0, 1'b0);
    check("perf stall_cnt sat",   DW'(stall_cnt),  DW'(15));
    check("perf bubble_cnt 4",    DW'(bubble_cnt), DW'(4));
    step(1'b0, 1'b1, 1'b0, '0, 1'b0);
    check("perf flush out_valid", DW'(out_valid),  DW'(1'b0));
    check("perf flush stall_cnt", DW'(stall_cnt),  DW'(15));
    check("perf flush bubble",    DW'(bubble_cnt), DW'(4));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
